sprite_arbiter: RTL and testbench
=================================

# sprite_arbiter

Pixel-level compositor and arbiter for the shared VGA colour path. Each cycle it decides which of the Mario, Kong, Queue or background colour sources owns `vga_data`. It applies transparency keying, a frame-synchronous priority setting and game-state overrides. It also accumulates per-frame sprite collision flags that drive `over`/`success` into `state_fsm`. It sits between the sprite colour generators and `VGA_driver`, clocked by the pixel clock.

## Interface
- `H_ACT`, 640, visible columns
- `V_ACT`, 480, visible rows
- `KEY_COLOR`, 12'hF0F, transparent colour code in sprite images
- `M_W`/`M_H`/`M_OX`/`M_OY`, 60/80/30/40, Mario box size and anchor offset
- `K_W`/`K_H`/`K_OX`/`K_OY`, 120/160/60/80, Kong box
- `Q_W`/`Q_H`/`Q_OX`/`Q_OY`, 60/100/30/50, Queue box
- `clk`  in  1  pixel clock (`clk_div[1]`)
- `rst`  in  1  asynchronous, active-low reset
- `x`  in  10  scan column
- `y`  in  9  scan row
- `frame_tick`  in  1  one-cycle pulse once per frame, during vertical blanking
- `game_state`  in  2  00 INITIAL, 01 RUNNING, 10 OVER, 11 SUCCESS
- `mario_x`, `kong_x`, `queue_x`  in  10 each  sprite anchor column
- `mario_y`, `kong_y`, `queue_y`  in  9 each  sprite anchor row
- `mario_rgb`, `kong_rgb`, `queue_rgb`, `bg_rgb`  in  12 each  source colours, valid one cycle after the matching `x`/`y`
- `kong_front`  in  1  priority request: 1 puts Kong above Mario
- `vga_data`  out  12  composited pixel, registered
- `hit_kong`  out  1  Mario overlapped Kong in the last completed frame
- `hit_queue`  out  1  Mario overlapped Queue in the last completed frame
- `frame_cnt`  out  8  completed-frame counter

## Operation
- Stage 0 (registered):
  - Box hit for each sprite: `rx = (x + OX - cx) mod 1024`, `ry = (y + OY - cy) mod 512`.
  - Hit iff `rx < W` and `ry < H`. The modulo wrap is deliberate: it clips boxes at the left and top edges with no signed arithmetic.
  - Active flag = `x < H_ACT` and `y < V_ACT`.
  - `game_state` is registered alongside.
- Stage 1 (registered into `vga_data`):
  - A sprite is opaque iff its delayed hit = 1 and its rgb ≠ `KEY_COLOR`.
  - Inactive pixel → 12'h000.
  - INITIAL → 12'hF00.
  - SUCCESS → 12'h00F.
  - OVER → `bg_rgb`.
  - RUNNING with `prio` = 0: Mario > Kong > Queue > background.
  - RUNNING with `prio` = 1: Kong > Mario > Queue > background.
- Priority shadow: `prio` loads `kong_front` only on `frame_tick`, so the order never changes mid-frame.
- Collision accumulators `acc_k` and `acc_q`:
  - They set in RUNNING, on active pixels only, when Mario is opaque and Kong (or Queue) is opaque in the same stage-1 cycle. Priority does not matter.
  - They are sticky until `frame_tick`.
- On `frame_tick`:
  - `hit_kong <= acc_k`, `hit_queue <= acc_q`.
  - Both accumulators clear to 0.
  - `frame_cnt` increments, wrapping 255→0.
  - A collision in the same cycle as `frame_tick` is discarded. That cycle is blanking and cannot be active.
- Outside RUNNING the accumulators hold at 0, so `hit_*` reads 0 one frame after leaving RUNNING.

## Timing
- Latency: `x`/`y` at cycle t → `vga_data` at t+2. Source rgb at t+1 is used.
- Throughput: one pixel per cycle, no stalls.
- `hit_*` and `frame_cnt` change only on the cycle after `frame_tick`. They are stable for a whole frame.
- Reset (`rst` = 0, asynchronous) clears everything immediately: `vga_data` = 0, `hit_kong` = `hit_queue` = 0, `frame_cnt` = 0, `prio` = 0, accumulators = 0, and all stage-0 registers (hits, active, state) = 0.
- Reset release is synchronous to `clk`. The first valid pixel appears 2 cycles after release.
- Reset mid-frame drops the partial frame's collisions.
- Two `frame_tick` pulses on consecutive cycles: the second publishes 0s and counts again.

## Test plan
- Reset, then `game_state` = 00 with any `x`/`y` in the active area → `vga_data` = 12'hF00 from cycle t+2. Before reset release, `vga_data` = 0 and `frame_cnt` = 0.
- RUNNING, Mario at (100,100), `x`=100, `y`=100, `mario_rgb` = 12'h123 → 12'h123 at t+2. With `mario_rgb` = 12'hF0F → `bg_rgb` shows.
- Mario and Kong both at (200,200), opaque, `kong_front` = 0 → Mario's colour. Set `kong_front` = 1 mid-frame → Mario's colour persists until `frame_tick`, then Kong's colour.
- Mario at (10,10), pixel `x`=0, `y`=0 → hit, since rx = 20 < 60. Pixel `x`=700 → 12'h000 (inactive) and no hit.
- Overlapping opaque Mario and Kong over one frame, then `frame_tick` → `hit_kong` = 1, `hit_queue` = 0, `frame_cnt` = 1. Next frame with no overlap → `hit_kong` = 0 after the next tick.
- Switch to SUCCESS during an overlap → `vga_data` = 12'h00F and no accumulation. `hit_*` = 0 after the following tick.

Source files
------------

// File: rtl/sprite_arbiter_if.sv
// Bundle of scan, sprite and composited-pixel signals between the sprite
// colour generators / VGA driver side (master) and the arbiter (slave).
interface sprite_arbiter_if;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        frame_tick;
    logic [1:0]  game_state;
    logic [9:0]  mario_x;
    logic [8:0]  mario_y;
    logic [9:0]  kong_x;
    logic [8:0]  kong_y;
    logic [9:0]  queue_x;
    logic [8:0]  queue_y;
    logic [11:0] mario_rgb;
    logic [11:0] kong_rgb;
    logic [11:0] queue_rgb;
    logic [11:0] bg_rgb;
    logic        kong_front;
    logic [11:0] vga_data;
    logic        hit_kong;
    logic        hit_queue;
    logic [7:0]  frame_cnt;

    modport master (
        output x, y, frame_tick, game_state,
        output mario_x, mario_y, kong_x, kong_y, queue_x, queue_y,
        output mario_rgb, kong_rgb, queue_rgb, bg_rgb, kong_front,
        input  vga_data, hit_kong, hit_queue, frame_cnt
    );

    modport slave (
        input  x, y, frame_tick, game_state,
        input  mario_x, mario_y, kong_x, kong_y, queue_x, queue_y,
        input  mario_rgb, kong_rgb, queue_rgb, bg_rgb, kong_front,
        output vga_data, hit_kong, hit_queue, frame_cnt
    );
endinterface

// File: rtl/sprite_arbiter.sv
// Two-stage pixel compositor: stage 0 computes sprite box hits from the scan
// position, stage 1 keys out transparent pixels, applies game-state overrides
// and layer priority, and accumulates per-frame Mario collision flags.
module sprite_arbiter #(
    parameter int          H_ACT     = 640,
    parameter int          V_ACT     = 480,
    parameter logic [11:0] KEY_COLOR = 12'hF0F,
    parameter int          M_W = 60,  M_H = 80,  M_OX = 30, M_OY = 40,
    parameter int          K_W = 120, K_H = 160, K_OX = 60, K_OY = 80,
    parameter int          Q_W = 60,  Q_H = 100, Q_OX = 30, Q_OY = 50
) (
    input logic              clk,
    input logic              rst,
    sprite_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_INITIAL = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_OVER    = 2'b10;
    localparam logic [1:0] ST_SUCCESS = 2'b11;

    // Box-relative coordinates; the unsigned wrap pushes pixels left of or
    // above a box far out of range, which clips boxes at the screen edges.
    logic [9:0] m_rx, k_rx, q_rx;
    logic [8:0] m_ry, k_ry, q_ry;

    assign m_rx = bus.x + 10'(M_OX) - bus.mario_x;
    assign m_ry = bus.y + 9'(M_OY)  - bus.mario_y;
    assign k_rx = bus.x + 10'(K_OX) - bus.kong_x;
    assign k_ry = bus.y + 9'(K_OY)  - bus.kong_y;
    assign q_rx = bus.x + 10'(Q_OX) - bus.queue_x;
    assign q_ry = bus.y + 9'(Q_OY)  - bus.queue_y;

    logic       m_hit, k_hit, q_hit;
    logic       active_d;
    logic [1:0] state_d;

    // Stage 0: register box hits, active-area flag and game state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_hit    <= 1'b0;
            k_hit    <= 1'b0;
            q_hit    <= 1'b0;
            active_d <= 1'b0;
            state_d  <= ST_INITIAL;
        end else begin
            m_hit    <= (m_rx < 10'(M_W)) && (m_ry < 9'(M_H));
            k_hit    <= (k_rx < 10'(K_W)) && (k_ry < 9'(K_H));
            q_hit    <= (q_rx < 10'(Q_W)) && (q_ry < 9'(Q_H));
            active_d <= (bus.x < 10'(H_ACT)) && (bus.y < 9'(V_ACT));
            state_d  <= bus.game_state;
        end
    end

    logic m_op, k_op, q_op;

    assign m_op = m_hit && (bus.mario_rgb != KEY_COLOR);
    assign k_op = k_hit && (bus.kong_rgb  != KEY_COLOR);
    assign q_op = q_hit && (bus.queue_rgb != KEY_COLOR);

    logic        prio;
    logic [11:0] pix_next;

    // Stage 1 colour select: blanking, state overrides, then layer order.
    // NOTE: pix_next gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pix_next = bus.bg_rgb;
        if (!active_d) begin
            pix_next = 12'h000;
        end else begin
            case (state_d)
                ST_INITIAL: pix_next = 12'hF00;
                ST_SUCCESS: pix_next = 12'h00F;
                ST_OVER:    pix_next = bus.bg_rgb;
                default: begin
                    if (prio && k_op)        pix_next = bus.kong_rgb;
                    else if (m_op)           pix_next = bus.mario_rgb;
                    else if (k_op)           pix_next = bus.kong_rgb;
                    else if (q_op)           pix_next = bus.queue_rgb;
                    else                     pix_next = bus.bg_rgb;
                end
            endcase
        end
    end

    // Stage 1 output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bus.vga_data <= 12'h000;
        else      bus.vga_data <= pix_next;
    end

    // Priority shadow: only changes at frame boundaries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                prio <= 1'b0;
        else if (bus.frame_tick) prio <= bus.kong_front;
    end

    logic acc_k, acc_q;

    // Collision accumulators and per-frame publication; a collision seen on
    // the tick cycle itself is dropped since that cycle is blanking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_k         <= 1'b0;
            acc_q         <= 1'b0;
            bus.hit_kong  <= 1'b0;
            bus.hit_queue <= 1'b0;
            bus.frame_cnt <= 8'd0;
        end else if (bus.frame_tick) begin
            bus.hit_kong  <= acc_k;
            bus.hit_queue <= acc_q;
            acc_k         <= 1'b0;
            acc_q         <= 1'b0;
            bus.frame_cnt <= bus.frame_cnt + 8'd1;
        end else if (state_d != ST_RUNNING) begin
            acc_k <= 1'b0;
            acc_q <= 1'b0;
        end else if (active_d && m_op) begin
            if (k_op) acc_k <= 1'b1;
            if (q_op) acc_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sprite_arbiter.sv
// Directed testbench for sprite_arbiter with hand-computed expected values.
module tb_sprite_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    sprite_arbiter_if bus ();

    sprite_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [9:0] px, input logic [8:0] py);
        bus.x = px;
        bus.y = py;
    endtask

    task automatic frame_pulse();
        bus.frame_tick = 1'b1;
        tick(1);
        bus.frame_tick = 1'b0;
    endtask

    // Move the scan off-screen and let the pipeline empty before a tick.
    task automatic drain_and_tick();
        pix(10'd700, 9'd100);
        tick(2);
        frame_pulse();
    endtask

    localparam logic [11:0] BG = 12'h0A5;
    localparam logic [11:0] MC = 12'h123;
    localparam logic [11:0] KC = 12'h456;
    localparam logic [11:0] QC = 12'h789;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst            = 1'b0;
        bus.frame_tick = 1'b0;
        bus.game_state = 2'b00;
        bus.kong_front = 1'b0;
        bus.mario_x = 10'd100; bus.mario_y = 9'd100;
        bus.kong_x  = 10'd500; bus.kong_y  = 9'd400;
        bus.queue_x = 10'd500; bus.queue_y = 9'd100;
        bus.mario_rgb = MC; bus.kong_rgb = KC;
        bus.queue_rgb = QC; bus.bg_rgb   = BG;
        pix(10'd50, 9'd50);

        // Held in reset
        tick(3);
        check("rst_vga", bus.vga_data, 12'h000);
        check("rst_cnt", bus.frame_cnt, 8'd0);
        check("rst_hitk", bus.hit_kong, 1'b0);

        // Release; INITIAL colour after two cycles
        rst = 1'b1;
        tick(1);
        check("init_t1", bus.vga_data, 12'h000);
        tick(1);
        check("init_t2", bus.vga_data, 12'hF00);

        // RUNNING, Mario alone, latency and transparency
        bus.game_state = 2'b01;
        pix(10'd700, 9'd100);
        tick(2);
        check("inactive", bus.vga_data, 12'h000);
        pix(10'd100, 9'd100);
        tick(1);
        check("lat_t1", bus.vga_data, 12'h000);
        tick(1);
        check("mario", bus.vga_data, MC);
        bus.mario_rgb = 12'hF0F;
        tick(1);
        check("key_bg", bus.vga_data, BG);
        bus.mario_rgb = MC;

        // Right box edge: rx = 59 inside, rx = 60 outside
        pix(10'd129, 9'd100);
        tick(2);
        check("edge_in", bus.vga_data, MC);
        pix(10'd130, 9'd100);
        tick(2);
        check("edge_out", bus.vga_data, BG);

        // Left/top clipping via wrap
        bus.mario_x = 10'd10; bus.mario_y = 9'd10;
        pix(10'd0, 9'd0);
        tick(2);
        check("clip_hit", bus.vga_data, MC);
        pix(10'd700, 9'd0);
        tick(2);
        check("clip_inact", bus.vga_data, 12'h000);
        bus.mario_x = 10'd100;
        pix(10'd0, 9'd0);
        tick(2);
        check("wrap_miss", bus.vga_data, BG);

        // Mario over Kong, priority shadowed until frame_tick
        bus.mario_x = 10'd200; bus.mario_y = 9'd200;
        bus.kong_x  = 10'd200; bus.kong_y  = 9'd200;
        pix(10'd200, 9'd200);
        tick(2);
        check("prio0", bus.vga_data, MC);
        bus.kong_front = 1'b1;
        tick(5);
        check("prio_mid", bus.vga_data, MC);
        check("hitk_stable", bus.hit_kong, 1'b0);
        drain_and_tick();
        check("f1_hitk", bus.hit_kong, 1'b1);
        check("f1_hitq", bus.hit_queue, 1'b0);
        check("f1_cnt", bus.frame_cnt, 8'd1);
        pix(10'd200, 9'd200);
        tick(2);
        check("prio1", bus.vga_data, KC);
        drain_and_tick();
        check("f2_hitk", bus.hit_kong, 1'b1);
        check("f2_cnt", bus.frame_cnt, 8'd2);

        // Kong away, Queue overlaps Mario
        bus.kong_x  = 10'd500; bus.kong_y  = 9'd400;
        bus.queue_x = 10'd200; bus.queue_y = 9'd200;
        pix(10'd200, 9'd200);
        tick(2);
        check("m_over_q", bus.vga_data, MC);
        drain_and_tick();
        check("f3_hitk", bus.hit_kong, 1'b0);
        check("f3_hitq", bus.hit_queue, 1'b1);
        check("f3_cnt", bus.frame_cnt, 8'd3);

        // Back-to-back ticks: second publishes zeros
        pix(10'd200, 9'd200);
        tick(3);
        pix(10'd700, 9'd100);
        tick(2);
        bus.frame_tick = 1'b1;
        tick(1);
        check("dbl1_hitq", bus.hit_queue, 1'b1);
        check("dbl1_cnt", bus.frame_cnt, 8'd4);
        tick(1);
        bus.frame_tick = 1'b0;
        check("dbl2_hitq", bus.hit_queue, 1'b0);
        check("dbl2_cnt", bus.frame_cnt, 8'd5);

        // Collision landing on the tick cycle is discarded
        pix(10'd200, 9'd200);
        tick(1);
        pix(10'd700, 9'd100);
        bus.frame_tick = 1'b1;
        tick(1);
        bus.frame_tick = 1'b0;
        check("tick_pix", bus.vga_data, MC);
        check("tick_cnt", bus.frame_cnt, 8'd6);
        drain_and_tick();
        check("discard_hitq", bus.hit_queue, 1'b0);
        check("discard_cnt", bus.frame_cnt, 8'd7);

        // SUCCESS / OVER overrides with no accumulation
        bus.game_state = 2'b11;
        pix(10'd200, 9'd200);
        tick(2);
        check("success", bus.vga_data, 12'h00F);
        bus.game_state = 2'b10;
        tick(2);
        check("over_bg", bus.vga_data, BG);
        drain_and_tick();
        check("succ_hitq", bus.hit_queue, 1'b0);
        check("succ_hitk", bus.hit_kong, 1'b0);
        check("succ_cnt", bus.frame_cnt, 8'd8);

        // Asynchronous reset mid-frame drops partial collisions
        bus.game_state = 2'b01;
        pix(10'd200, 9'd200);
        tick(3);
        check("pre_rst", bus.vga_data, MC);
        #3;
        rst = 1'b0;
        #1;
        check("async_vga", bus.vga_data, 12'h000);
        check("async_cnt", bus.frame_cnt, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.queue_x = 10'd500; bus.queue_y = 9'd100;
        bus.kong_x  = 10'd200; bus.kong_y  = 9'd200;
        tick(2);
        check("rst_prio0", bus.vga_data, MC);
        drain_and_tick();
        check("post_hitk", bus.hit_kong, 1'b1);
        check("post_hitq", bus.hit_queue, 1'b0);
        check("post_cnt", bus.frame_cnt, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
